// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package prefetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   localparam logic [31:0] NOP           = 32'h0;
   localparam int          DEFAULT_DEPTH = 4;
   localparam int          ENTRY_W       = 64;

endpackage

// File: rtl/prefetch_fifo.sv
// Small register FIFO holding {instruction, PC+4} entries; head is always visible.
module prefetch_fifo
   import prefetch_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic               i_clear,
   input  logic [ENTRY_W-1:0] i_wdata,
   output logic [ENTRY_W-1:0] o_rdata,
   output logic [CW-1:0]      o_count,
   output logic               o_empty,
   output logic               o_full
);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Clear wins over a simultaneous push/pop: the whole path is being flushed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_do_push && !w_do_pop)
            r_count <= r_count + CW'(1);
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_clear)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: fetch FSM with redirect handling in front of a small FIFO to decode.
module instr_prefetch
   import prefetch_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        d_valid,
   output logic [31:0] d_inst,
   output logic [31:0] d_pc,
   input  logic        d_ready
);

   localparam int CW = $clog2(DEPTH + 1);

   state_t             r_state;
   logic [31:0]        r_fetch_pc;
   logic [31:0]        r_target;
   logic [CW-1:0]      w_count;
   logic               w_empty;
   logic               w_full;
   logic [ENTRY_W-1:0] w_head;
   logic               w_pop;
   logic               w_push;
   logic [CW:0]        w_count_after;

   assign w_pop         = d_valid & d_ready;
   assign w_push        = imem_ack & (r_state == ST_WAIT) & ~redirect;
   assign w_count_after = {1'b0, w_count} + (CW + 1)'(1) - (CW + 1)'(w_pop);

   // A request is only issued while a FIFO slot is guaranteed for its data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_target   <= RESET_PC;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (redirect)
                  r_fetch_pc <= redirect_pc;
               else if (!w_full)
                  r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (redirect && !imem_ack) begin
                  r_target <= redirect_pc;
                  r_state  <= ST_DROP;
               end else if (redirect && imem_ack) begin
                  r_fetch_pc <= redirect_pc;
                  r_state    <= ST_IDLE;
               end else if (imem_ack) begin
                  r_fetch_pc <= r_fetch_pc + 32'd4;
                  if (w_count_after < (CW + 1)'(DEPTH))
                     r_state <= ST_WAIT;
                  else
                     r_state <= ST_IDLE;
               end
            end
            ST_DROP: begin
               // Address stays on the stale fetch until memory completes it.
               if (redirect)
                  r_target <= redirect_pc;
               if (imem_ack) begin
                  r_fetch_pc <= redirect ? redirect_pc : r_target;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (redirect),
      .i_wdata ({imem_rdata, r_fetch_pc + 32'd4}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign imem_req  = (r_state != ST_IDLE);
   assign imem_addr = r_fetch_pc;
   assign d_valid   = !w_empty;
   assign d_inst    = d_valid ? w_head[63:32] : NOP;
   assign d_pc      = d_valid ? w_head[31:0]  : NOP;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: bench-side memory responder plus a scoreboard of fetched words.
module tb_instr_prefetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        d_valid;
   logic [31:0] d_inst;
   logic [31:0] d_pc;
   logic        d_ready = 1'b1;

   int n_checks = 0;
   int n_err    = 0;
   int mem_lat  = 0;
   int budget   = 0;
   int wait_cnt = 0;
   logic [63:0] exp_q[$];

   instr_prefetch #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .d_valid     (d_valid),
      .d_inst      (d_inst),
      .d_pc        (d_pc),
      .d_ready     (d_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
      end else
         $display("ok   %s: %h (t=%0t)", name, got, $time);
   endtask

   task automatic expect_word(input logic [31:0] a);
      exp_q.push_back({word_of(a), a + 32'd4});
   endtask

   // Memory: acks after mem_lat idle cycles, only while budget remains.
   always @(negedge clk) begin
      imem_ack = 1'b0;
      if (imem_req && budget > 0) begin
         if (wait_cnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = word_of(imem_addr);
            budget     = budget - 1;
            wait_cnt   = 0;
         end else
            wait_cnt = wait_cnt + 1;
      end else
         wait_cnt = 0;
   end

   // Scoreboard monitor: every accepted word must match the queue head.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst && !redirect && d_valid && d_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_pop: got inst=%h pc=%h required no word", d_inst, d_pc);
         end else begin
            e = exp_q.pop_front();
            chk("pop_inst", d_inst, e[63:32]);
            chk("pop_pc", d_pc, e[31:0]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;

      // Reset values
      #3;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, d_valid}, 32'd0);
      chk("rst_inst", d_inst, 32'h0);
      chk("rst_pc", d_pc, 32'h0);

      // Streaming: ack every cycle, decode always ready
      for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
      budget = 8;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("stream_req", {31'b0, imem_req}, 32'd1);
         chk("stream_addr", imem_addr, 32'(k * 4));
         if (k == 0) chk("first_valid_low", {31'b0, d_valid}, 32'd0);
         if (k == 1) chk("first_valid_high", {31'b0, d_valid}, 32'd1);
      end
      repeat (4) @(posedge clk);

      // Fill with decode stalled: exactly four pushes, then requests stop
      #1 d_ready = 1'b0; budget = 6;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("full_req", {31'b0, imem_req}, 32'd0);
      chk("full_addr", imem_addr, 32'h30);
      chk("full_valid", {31'b0, d_valid}, 32'd1);
      chk("full_head_pc", d_pc, 32'h24);
      chk("full_head_inst", d_inst, word_of(32'h20));
      for (int i = 0; i < 6; i++) expect_word(32'h20 + 32'(i * 4));
      @(posedge clk); #1 d_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("resume_req", {31'b0, imem_req}, 32'd1);
      chk("resume_addr", imem_addr, 32'h38);

      // Redirect while waiting on a slow ack: stale word must be dropped
      @(posedge clk);
      #1 redirect = 1'b1; redirect_pc = 32'h40; mem_lat = 3; budget = 3;
      expect_word(32'h40);
      expect_word(32'h44);
      @(posedge clk); #1 redirect = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("drop_hold_addr", imem_addr, 32'h38);
         chk("drop_valid", {31'b0, d_valid}, 32'd0);
      end
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr == 32'h40) found = 1'b1;
      end
      chk("drop_new_path_seen", {31'b0, found}, 32'd1);
      repeat (16) @(posedge clk);

      // Redirect coinciding with an ack
      @(posedge clk);
      #1 mem_lat = 0; budget = 1; redirect = 1'b1; redirect_pc = 32'h80;
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("coinc_req_low", {31'b0, imem_req}, 32'd0);
      chk("coinc_valid", {31'b0, d_valid}, 32'd0);
      chk("coinc_addr", imem_addr, 32'h80);
      @(posedge clk); #1 budget = 2;
      expect_word(32'h80);
      expect_word(32'h84);
      @(negedge clk);
      chk("coinc_req", {31'b0, imem_req}, 32'd1);
      chk("coinc_new_addr", imem_addr, 32'h80);
      repeat (6) @(posedge clk);

      // count = 3 in WAIT with simultaneous ack and pop
      @(posedge clk);
      #1 d_ready = 1'b0; budget = 3;
      for (int i = 0; i < 5; i++) expect_word(32'h88 + 32'(i * 4));
      repeat (3) @(posedge clk);
      #1 budget = 1; d_ready = 1'b1;
      @(posedge clk);
      #1 d_ready = 1'b0; budget = 5;
      @(negedge clk);
      chk("c3_req", {31'b0, imem_req}, 32'd1);
      chk("c3_addr", imem_addr, 32'h98);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("c3_full_req", {31'b0, imem_req}, 32'd0);
      chk("c3_full_addr", imem_addr, 32'h9C);
      chk("c3_head_pc", d_pc, 32'h90);

      // Drain, then buffer two words and hit reset mid-WAIT
      @(posedge clk); #1 budget = 0; d_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1 d_ready = 1'b0; budget = 2;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_valid", {31'b0, d_valid}, 32'd1);
      chk("pre_rst_addr", imem_addr, 32'hA4);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_req", {31'b0, imem_req}, 32'd0);
      chk("async_rst_addr", imem_addr, 32'h0);
      chk("async_rst_valid", {31'b0, d_valid}, 32'd0);
      chk("async_rst_inst", d_inst, 32'h0);
      chk("async_rst_pc", d_pc, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1; budget = 2; d_ready = 1'b1;
      expect_word(32'h0);
      expect_word(32'h4);
      @(posedge clk);
      @(negedge clk);
      chk("restart_req", {31'b0, imem_req}, 32'd1);
      chk("restart_addr", imem_addr, 32'h0);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch stage between instruction memory and the IF/ID pipe register. It generates fetch addresses, fetches through a request/acknowledge handshake from an instruction memory of variable latency, and buffers fetched words with their PC+4 in a small FIFO. It delivers instructions to decode through a valid/ready handshake and flushes itself on branch/jump redirects coming from the memory stage.

## Interface
Parameters:
- DEPTH, 4: FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0: first fetch address after reset

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- redirect  in  1  taken branch or jump (pc_src | m_jump)
- redirect_pc  in  32  target address, valid with redirect
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  imem_rdata valid this cycle; completes request
- imem_rdata  in  32  instruction word
- d_valid  out  1  FIFO head valid
- d_inst  out  32  head instruction; 0 (nop) when !d_valid
- d_pc  out  32  head PC+4; 0 when !d_valid
- d_ready  in  1  decode accepts head (low on hazard stall)

## Operation
- Registers: fetch_pc (32), state, FIFO count (0..DEPTH), read/write pointers (log2 DEPTH, wrap modulo DEPTH).
- States: IDLE (no request outstanding), WAIT (request outstanding, data kept), DROP (request outstanding, data discarded).
- imem_req = (state != IDLE); imem_addr = fetch_pc. Address held stable while req is high until ack.
- pop = d_valid & d_ready; push = imem_ack & (state == WAIT) & !redirect. Entry = {imem_rdata, fetch_pc+4}.
- IDLE: redirect → fetch_pc = redirect_pc, stay IDLE; else if count < DEPTH → WAIT.
- WAIT: redirect & !ack → DROP, fetch_pc unchanged until ack. Redirect & ack → discard data, fetch_pc = redirect_pc, IDLE. Ack without redirect → push, fetch_pc += 4. Stay in WAIT if (count + 1 − pop) < DEPTH; otherwise go to IDLE.
- DROP: ack → discard, fetch_pc = redirect target latched on entry, IDLE. A new redirect while in DROP overwrites the latched target.
- Redirect in any state clears the FIFO next cycle (count = 0, pointers = 0). A pop in the same cycle is harmless because decode flushes too.
- An ack while in IDLE is ignored.
- Push and pop in the same cycle leave count unchanged. Push never occurs at count == DEPTH, since a request is only outstanding when a slot is reserved.
- fetch_pc arithmetic is 32-bit modulo. Low two address bits are never checked.

## Timing
- Reset (asynchronous, immediate): state IDLE, fetch_pc = RESET_PC, count = 0, imem_req 0, imem_addr RESET_PC, d_valid 0, d_inst 0, d_pc 0. Reset asserted mid-WAIT abandons the request; the memory side must tolerate a dropped request.
- First imem_req: cycle 1 after reset release.
- Latency: ack at edge N → d_valid at N+1.
- Throughput: one instruction per cycle when ack is high every cycle and d_ready = 1.
- Redirect at edge N → FIFO empty and d_valid = 0 at N+1. First new-path request:
  - at N+1 if no request was outstanding or ack coincided with redirect;
  - otherwise the cycle after the pending ack.
- d_valid, d_inst, d_pc are driven from FIFO registers; there is no combinational path from imem_* to d_*.

## Structure
- Shared package `prefetch_pkg`: state enum (IDLE, WAIT, DROP), NOP = 32'h0, default DEPTH.
- One sub-module, `prefetch_fifo`: DEPTH × 64-bit storage, push/pop/clear, count/empty/full. All FSM and address logic lives in instr_prefetch.

## Test plan
- Reset release, ack every cycle, d_ready = 1 → imem_addr 0,4,8,… on consecutive cycles; d_valid first high cycle 2 with d_pc = 4; one instruction per cycle after that.
- d_ready = 0, ack every cycle → exactly 4 pushes, imem_req low after the 4th ack, count = 4. Then d_ready = 1 → words drain in order 0,4,8,12 (d_pc 4..16) and requests resume.
- Redirect to 0x40 in WAIT at addr 0x8, ack delayed 3 cycles → imem_addr held at 0x8 until ack; that data never appears; next request addr 0x40; first d_pc = 0x44.
- Redirect to 0x80 in the same cycle as an ack → data discarded, FIFO empty next cycle, next imem_addr = 0x80 one cycle later.
- count = 3 in WAIT, ack and pop in the same cycle → count stays 3, imem_req stays high at addr+4.
- Async reset asserted mid-WAIT with 2 entries buffered → all outputs at reset values before the next clock edge; after release, fetch restarts at RESET_PC.
